// File: rtl/fc3_stream_stage.sv
// fc3_stream_stage
//
// Third fully-connected LeNet stage (N_OUT = 120 neurons). Each accepted cycle
// brings one signed activation and a row of N_OUT signed weights from upstream
// ROMs. The stage accumulates N_OUT dot products in parallel. After N_IN
// samples it quantizes every accumulator (arithmetic shift, optional ReLU,
// 16-bit saturation). It then streams the results one per cycle to layer 4,
// together with the matching weight-ROM address.
//
// Optional feature macro: FC3_RELU_EN
//   defined   : negative shifted results are clamped to 0 before saturation
//   undefined : signed results pass straight to saturation
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset, clears all state
//   ena            in   upstream ROM read enable (same cycle as ROM address)
//   din            in   signed activation, valid 2 cycles after its ena
//   weight_in      in   N_OUT signed weights, neuron j at [16j+15:16j]
//   fc_finish      out  sticky done flag
//   save           out  one-cycle pulse when the result vector is registered
//   layer4_en      out  high while l4_din is valid
//   l4_din         out  signed streamed neuron output
//   l4_weight_addr out  index of the neuron currently on l4_din

module fc3_stream_stage #(
    parameter int N_IN   = 256,
    parameter int N_OUT  = 120,
    parameter int FRAC   = 8,
    parameter int DATA_W = 18,
    parameter int COEF_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ena,
    input  logic signed [DATA_W-1:0]  din,
    input  logic [N_OUT*COEF_W-1:0]   weight_in,
    output logic                      fc_finish,
    output logic                      save,
    output logic                      layer4_en,
    output logic signed [15:0]        l4_din,
    output logic [7:0]                l4_weight_addr
);

    localparam int OUT_W  = 16;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = 40;
    localparam int CNT_W  = $clog2(N_IN + 1);
    localparam int K_W    = $clog2(N_OUT);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    // Arithmetic right shift, then optional ReLU.
    function automatic logic signed [ACC_W-1:0] scale_relu(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W-1:0] y;
        y = a >>> FRAC;
`ifdef FC3_RELU_EN
        if (y < 0) y = '0;
`endif
        return y;
    endfunction

    // Clamp to the signed 16-bit output range.
    function automatic logic signed [OUT_W-1:0] sat16(
        input logic signed [ACC_W-1:0] y
    );
        if (y > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
        else if (y < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        else                  return y[OUT_W-1:0];
    endfunction

    // ---------------- p1/p2: ena delay matching ROM read latency ----------------
    logic ena_p1, ena_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ena_p1 <= 1'b0;
            ena_p2 <= 1'b0;
        end else begin
            ena_p1 <= ena;
            ena_p2 <= ena_p1;
        end
    end

    // ---------------- p2: parallel multiply-accumulate ----------------
    logic signed [PROD_W-1:0] prod [N_OUT];
    logic signed [ACC_W-1:0]  acc_p2 [N_OUT];
    logic [CNT_W-1:0]         cnt_p2;
    logic                     last_p2;
    logic                     accept;

    for (genvar gj = 0; gj < N_OUT; gj++) begin : g_mul
        logic signed [COEF_W-1:0] w_j;
        assign w_j      = weight_in[gj*COEF_W +: COEF_W];
        assign prod[gj] = din * w_j;
    end

    // Samples are blocked both once finished and in the single cycle between
    // the last accepted sample and the registration of the results.
    assign accept = ena_p2 && !fc_finish && !last_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < N_OUT; j++) acc_p2[j] <= '0;
            cnt_p2  <= '0;
            last_p2 <= 1'b0;
        end else begin
            last_p2 <= accept && (cnt_p2 == CNT_W'(N_IN - 1));
            if (accept) begin
                cnt_p2 <= cnt_p2 + 1'b1;
                for (int j = 0; j < N_OUT; j++)
                    acc_p2[j] <= acc_p2[j] + ACC_W'(prod[j]);
            end
        end
    end

    // ---------------- p3: quantize and register result vector ----------------
    logic signed [OUT_W-1:0] res_p3 [N_OUT];
    logic                    save_p3;
    logic                    fin_p3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < N_OUT; j++) res_p3[j] <= '0;
            save_p3 <= 1'b0;
            fin_p3  <= 1'b0;
        end else begin
            save_p3 <= last_p2;
            if (last_p2) begin
                fin_p3 <= 1'b1;
                for (int j = 0; j < N_OUT; j++)
                    res_p3[j] <= sat16(scale_relu(acc_p2[j]));
            end
        end
    end

    assign save      = save_p3;
    assign fc_finish = fin_p3;

    // ---------------- p4: output buffer and serializer ----------------
    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state_p4, state_n;
    logic [K_W-1:0]          k_p4, k_n;
    logic signed [OUT_W-1:0] vec_p4 [N_OUT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p4 <= IDLE;
            k_p4     <= '0;
            for (int j = 0; j < N_OUT; j++) vec_p4[j] <= '0;
        end else begin
            state_p4 <= state_n;
            k_p4     <= k_n;
            if (save_p3) begin
                for (int j = 0; j < N_OUT; j++) vec_p4[j] <= res_p3[j];
            end
        end
    end

    // A save during STREAM relatches and restarts from neuron 0.
    always_comb begin
        state_n = state_p4;
        k_n     = k_p4;
        if (save_p3) begin
            state_n = STREAM;
            k_n     = '0;
        end else if (state_p4 == STREAM) begin
            if (k_p4 == K_W'(N_OUT - 1)) begin
                state_n = IDLE;
                k_n     = '0;
            end else begin
                k_n = k_p4 + 1'b1;
            end
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        layer4_en      = 1'b0;
        l4_din         = '0;
        l4_weight_addr = '0;
        if (state_p4 == STREAM) begin
            layer4_en      = 1'b1;
            l4_din         = vec_p4[k_p4];
            l4_weight_addr = 8'(k_p4);
        end
    end

endmodule

// File: tb/tb_fc3_stream_stage.sv
// Testbench for fc3_stream_stage: ramp, saturation, negative, gapped enable,
// reset mid-stream, post-finish enable and randomized data, all checked
// against a dot-product reference model.

module tb_fc3_stream_stage;

    localparam int N_IN  = 256;
    localparam int N_OUT = 120;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  ena;
    logic signed [17:0]    din;
    logic [N_OUT*16-1:0]   weight_in;
    logic                  fc_finish;
    logic                  save;
    logic                  layer4_en;
    logic signed [15:0]    l4_din;
    logic [7:0]            l4_weight_addr;

    fc3_stream_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ena            (ena),
        .din            (din),
        .weight_in      (weight_in),
        .fc_finish      (fc_finish),
        .save           (save),
        .layer4_en      (layer4_en),
        .l4_din         (l4_din),
        .l4_weight_addr (l4_weight_addr)
    );

    always #5 clk = ~clk;

    // ROM contents and expected neuron outputs
    logic signed [17:0] rom_din [N_IN];
    logic signed [15:0] rom_w   [N_IN][N_OUT];
    longint             exp_y   [N_OUT];

    int total = 0;
    int bad   = 0;

    // Per-run model state
    int e;           // index of the next clock edge since reset release
    int cnt;         // enables counted toward the inference
    int save_edge;   // edge after which save is expected
    int addr;        // upstream ROM address counter
    int hist [1024]; // ROM address issued at each edge, -1 if none

    task automatic chk(input string tag, input longint obs, input longint expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s (edge %0d): got %0d want %0d", tag, e, obs, expv);
        end
    endtask

    task automatic compute_exp();
        for (int j = 0; j < N_OUT; j++) begin
            longint s = 0;
            longint y;
            for (int i = 0; i < N_IN; i++)
                s += longint'(rom_din[i]) * longint'(rom_w[i][j]);
            y = s >>> 8;
`ifdef FC3_RELU_EN
            if (y < 0) y = 0;
`endif
            if (y > 32767) y = 32767;
            if (y < -32768) y = -32768;
            exp_y[j] = y;
        end
    endtask

    task automatic fill_const(input int dv, input int wv, input bit ramp_w);
        for (int i = 0; i < N_IN; i++) begin
            rom_din[i] = 18'(dv);
            for (int j = 0; j < N_OUT; j++)
                rom_w[i][j] = ramp_w ? 16'(j) : 16'(wv);
        end
        compute_exp();
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N_IN; i++) begin
            rom_din[i] = 18'(int'($urandom_range(0, 65535)) - 32768);
            for (int j = 0; j < N_OUT; j++)
                rom_w[i][j] = 16'($urandom);
        end
        compute_exp();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ena   = 1'b0;
        din   = '0;
        weight_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_save", save, 0);
        chk("rst_fc_finish", fc_finish, 0);
        chk("rst_layer4_en", layer4_en, 0);
        chk("rst_l4_din", l4_din, 0);
        chk("rst_l4_addr", l4_weight_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        e = 0;
        cnt = 0;
        save_edge = 1 << 30;
        addr = 0;
    endtask

    // One clock: drive ROM-aligned data, advance the model, check outputs.
    task automatic step(input bit en, inout int seen);
        int a, k;
        bit instr;
        longint ev;
        hist[e] = en ? addr : -1;
        if (en) addr = (addr + 1) % 256;
        ena = en;
        if (e >= 2 && hist[e-2] >= 0) begin
            a = hist[e-2];
            din = rom_din[a];
            for (int j = 0; j < N_OUT; j++) weight_in[16*j +: 16] = rom_w[a][j];
        end else begin
            din = 18'($urandom);
            for (int i = 0; i < N_OUT / 2; i++) weight_in[32*i +: 32] = $urandom;
        end
        @(posedge clk);
        if (en && cnt < N_IN) begin
            cnt++;
            if (cnt == N_IN) save_edge = e + 3;
        end
        #1;
        if (save && seen < 0) seen = e;
        instr = (e > save_edge) && (e <= save_edge + N_OUT);
        k = e - save_edge - 1;
        ev = 0;
        if (instr) ev = exp_y[k];
        chk("save", save, longint'(e == save_edge));
        chk("fc_finish", fc_finish, longint'(e >= save_edge));
        chk("layer4_en", layer4_en, longint'(instr));
        chk("l4_din", l4_din, ev);
        chk("l4_weight_addr", l4_weight_addr, instr ? k : 0);
        e++;
    endtask

    // mode 0: ena held high; 1: 5-cycle gap at sample 100; 2: random gaps.
    // abort_k >= 0 pulls reset low while neuron abort_k is on the output.
    task automatic run(input int mode, input int abort_k, output int seen);
        int sent = 0;
        int gapped = 0;
        bit en;
        do_reset();
        seen = -1;
        while (e < 900 && !(e > save_edge + N_OUT + 20)) begin
            en = 1'b1;
            if (mode == 1 && sent == 100 && gapped < 5) begin
                en = 1'b0;
                gapped++;
            end
            if (mode == 2) en = ($urandom_range(0, 3) != 0);
            if (en) sent++;
            step(en, seen);
            if (abort_k >= 0 && e - 1 == save_edge + 1 + abort_k) begin
                #2;
                reset = 1'b0;
                #1;
                chk("abort_layer4_en", layer4_en, 0);
                chk("abort_l4_din", l4_din, 0);
                chk("abort_l4_addr", l4_weight_addr, 0);
                chk("abort_fc_finish", fc_finish, 0);
                return;
            end
        end
        chk("save_seen", longint'(seen >= 0), 1);
    endtask

    initial begin
        int s;
        reset = 1'b0;
        ena = 1'b0;
        din = '0;
        weight_in = '0;

        fill_const(1, 0, 1'b1);
        run(0, -1, s);
        chk("ramp_save_edge", s, 258);

        run(1, -1, s);
        chk("gap_save_edge", s, 263);

        fill_const(256, 256, 1'b0);
        run(0, -1, s);

        fill_const(256, -1, 1'b0);
        run(0, -1, s);

        fill_const(1, 0, 1'b1);
        run(0, 50, s);
        run(0, -1, s);
        chk("rerun_save_edge", s, 258);

        fill_rand();
        run(2, -1, s);
        run(0, -1, s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc3_stream_stage.md
# fc3_stream_stage

Third fully-connected LeNet stage (120 neurons) with its input-enable alignment and output serializer. It consumes one 18-bit activation per cycle together with a 120-weight row from upstream ROMs and accumulates 120 dot products in parallel. After N_IN samples it quantizes the results and streams them one per cycle to layer 4, with a matching weight-ROM address.

## Interface
- N_IN, 256: input samples per inference; the upstream address is 8-bit.
- N_OUT, 120: neurons; fixed at 120 by the 1920-bit weight bus.
- FRAC, 8: arithmetic right shift applied to accumulator before saturation.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- ena  in  1  upstream ROM read enable, asserted in the same cycle as the ROM address.
- din  in  18  signed activation; ROM output, valid 2 cycles after its ena.
- weight_in  in  1920  120 signed 16-bit weights; neuron j at bits [16j+15:16j]; same 2-cycle alignment as din.
- fc_finish  out  1  sticky done flag.
- save  out  1  one-cycle pulse when the quantized result vector is registered.
- layer4_en  out  1  high while l4_din is valid.
- l4_din  out  16  signed streamed neuron output.
- l4_weight_addr  out  8  index k of the neuron currently on l4_din.

## Operation
- Align stage: two flops delay ena to ena_d, modelling ROM latency; reset value 0.
- MAC stage:
  - 120 accumulators, each 40-bit signed.
  - A sample is accepted when ena_d=1 and fc_finish=0: acc[j] += din*w[j], with a 34-bit signed product sign-extended. sample_cnt increments.
  - On the N_IN-th accepted sample the accumulators are final. Next cycle, for each j:
    - y = acc[j] >>> FRAC (arithmetic);
    - optional ReLU (see Configuration);
    - saturate to [-32768, 32767];
    - register into the 1920-bit result vector.
  - In that same cycle save=1 and fc_finish=1.
  - fc_finish stays 1 until reset. Later ena_d pulses are ignored, including samples from a wrapped upstream address.
- Buffer stage:
  - On save, latch the result vector, set k=0 and enter STREAM.
  - States IDLE and STREAM. In STREAM: layer4_en=1, l4_din=vec[16k+15:16k], l4_weight_addr=k, k increments each cycle.
  - After k=N_OUT-1, return to IDLE.
  - In IDLE: layer4_en=0, l4_din=0, l4_weight_addr=0.
  - A save arriving during STREAM relatches and restarts at k=0.
- Gaps in ena are allowed. Accumulation simply pauses; results are independent of gap placement.

## Timing
- Reset values: every output 0; all accumulators, counters and the vector 0; state IDLE.
- Reset asserted mid-accumulation or mid-stream aborts immediately, with outputs 0 at once. After release the block starts a fresh inference.
- Let ena be high continuously from edge E0, with no gaps:
  - samples accepted at edges E2..E(N_IN+1);
  - save and fc_finish rise after edge E(N_IN+2);
  - layer4_en high for edges E(N_IN+3)..E(N_IN+122), exactly 120 cycles, addresses 0..119.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- FC3_RELU_EN defined: y<0 becomes 0 before saturation, so l4_din is never negative.
- FC3_RELU_EN undefined: signed results pass through saturation unchanged.

## Test plan
- Ramp: din=1 always, w[j]=j, ena held 1.
  - acc[j]=256j, y=j.
  - layer4_en high 120 cycles; l4_din=k and l4_weight_addr=k for k=0..119.
  - save at E258, first layer4_en at E259.
- Saturation: din=256, all w=256.
  - acc=16777216, y=65536.
  - All l4_din=32767.
- Negative: din=256, all w=-1.
  - acc=-65536, y=-256.
  - l4_din=0 with FC3_RELU_EN, -256 without.
- Gapped enable: ramp case with ena dropped for 5 cycles at sample 100.
  - Identical l4_din sequence; save 5 cycles later.
- Reset mid-stream: pull reset low at k=50.
  - layer4_en, l4_din and fc_finish go 0 asynchronously.
  - After release, a fresh ramp run reproduces 0..119.
- Post-finish: keep ena high after fc_finish.
  - No second save; fc_finish stays 1; stream occurs once.
